// File: rtl/bpsk_framer_pkg.sv
// Shared types and defaults for the BPSK framing stage.
package bpsk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_PAYLOAD
   } state_t;

   localparam logic [7:0] SFD_DEFAULT          = 8'hD5;
   localparam int         PREAMBLE_LEN_DEFAULT = 32;
   localparam int         SYM_DIV_DEFAULT      = 16;

   // Holding-register contents: one payload byte plus its end-of-frame flag.
   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } byte_req_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bpsk_framer_symbol_strobe.sv
// Symbol-period divider: one-cycle tick every SYM_DIV cycles, restartable by clr.
module symbol_strobe #(
   parameter int SYM_DIV = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic tick
);

   localparam int            DW   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
   localparam logic [DW-1:0] WRAP = DW'(SYM_DIV - 1);

   logic [DW-1:0] div;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                     div <= '0;
      else if (clr || div == WRAP)  div <= '0;
      else                          div <= div + 1'b1;
   end

   // Tick sits in the first cycle of each period, so a clear lines the
   // next symbol up with the very next edge.
   assign tick = (div == '0);

endmodule

// File: rtl/bpsk_framer.sv
// Preamble + SFD + payload serialiser feeding the BPSK mapper, one bit per symbol period.
module bpsk_framer import bpsk_pkg::*; #(
   parameter int         SYM_DIV      = SYM_DIV_DEFAULT,
   parameter int         PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT,
   parameter logic [7:0] SFD          = SFD_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       byte_last,
   output logic       byte_ready,
   output logic       valid_o,
   output logic       data_o,
   output logic       busy_o,
   output logic       underrun_o
);

   localparam int             BCW      = $clog2(max2(PREAMBLE_LEN, 8)) + 1;
   localparam logic [BCW-1:0] PRE_LAST = BCW'(PREAMBLE_LEN - 1);
   localparam logic [BCW-1:0] BIT7     = BCW'(7);

   state_t         state, state_nxt;
   logic [BCW-1:0] bcnt, bcnt_nxt;
   logic [7:0]     shreg, shreg_nxt;
   logic           cur_last, cur_last_nxt;
   byte_req_t      hold, hold_nxt;
   logic           hold_full, hold_full_nxt;
   logic           last_seen, last_seen_nxt;
   logic           valid_nxt, data_nxt, under_nxt, busy_nxt, ready_nxt;
   logic           xfer, clr, tick;

   assign xfer = byte_valid & byte_ready;
   assign clr  = xfer && (state == ST_IDLE);

   symbol_strobe #(.SYM_DIV(SYM_DIV)) u_strobe (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (clr),
      .tick (tick)
   );

   always_comb begin
      state_nxt     = state;
      bcnt_nxt      = bcnt;
      shreg_nxt     = shreg;
      cur_last_nxt  = cur_last;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      last_seen_nxt = last_seen;
      valid_nxt     = 1'b0;
      data_nxt      = 1'b0;
      under_nxt     = 1'b0;

      if (xfer) begin
         hold_nxt      = '{data: byte_data, last: byte_last};
         hold_full_nxt = 1'b1;
         last_seen_nxt = last_seen | byte_last;
      end

      case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_nxt     = ST_PREAMBLE;
               bcnt_nxt      = '0;
               cur_last_nxt  = 1'b0;
               last_seen_nxt = byte_last;
            end
         end
         ST_PREAMBLE: begin
            if (tick) begin
               valid_nxt = 1'b1;
               data_nxt  = ~bcnt[0];
               if (bcnt == PRE_LAST) begin
                  state_nxt = ST_SFD;
                  bcnt_nxt  = '0;
                  shreg_nxt = SFD;
               end else begin
                  bcnt_nxt  = bcnt + 1'b1;
               end
            end
         end
         ST_SFD: begin
            if (tick) begin
               valid_nxt = 1'b1;
               data_nxt  = shreg[0];
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bcnt == BIT7) begin
                  state_nxt = ST_PAYLOAD;
                  bcnt_nxt  = '0;
               end else begin
                  bcnt_nxt  = bcnt + 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (tick) begin
               if (bcnt != '0) begin
                  valid_nxt = 1'b1;
                  data_nxt  = shreg[0];
                  shreg_nxt = {1'b0, shreg[7:1]};
                  bcnt_nxt  = (bcnt == BIT7) ? '0 : bcnt + 1'b1;
               end else if (cur_last) begin
                  // Final byte has had its full last symbol period.
                  state_nxt = ST_IDLE;
               end else if (hold_full) begin
                  valid_nxt     = 1'b1;
                  data_nxt      = hold.data[0];
                  shreg_nxt     = {1'b0, hold.data[7:1]};
                  cur_last_nxt  = hold.last;
                  hold_full_nxt = 1'b0;
                  bcnt_nxt      = BCW'(1);
               end else begin
                  // Byte missed its boundary; a transfer landing on this
                  // same edge is dropped along with the frame.
                  under_nxt     = 1'b1;
                  state_nxt     = ST_IDLE;
                  hold_full_nxt = 1'b0;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      busy_nxt  = (state_nxt != ST_IDLE);
      ready_nxt = (state_nxt == ST_IDLE) ||
                  (state_nxt == ST_PAYLOAD && !hold_full_nxt && !last_seen_nxt);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         bcnt       <= '0;
         shreg      <= '0;
         cur_last   <= 1'b0;
         hold       <= '0;
         hold_full  <= 1'b0;
         last_seen  <= 1'b0;
         valid_o    <= 1'b0;
         data_o     <= 1'b0;
         underrun_o <= 1'b0;
         busy_o     <= 1'b0;
         byte_ready <= 1'b0;
      end else begin
         state      <= state_nxt;
         bcnt       <= bcnt_nxt;
         shreg      <= shreg_nxt;
         cur_last   <= cur_last_nxt;
         hold       <= hold_nxt;
         hold_full  <= hold_full_nxt;
         last_seen  <= last_seen_nxt;
         valid_o    <= valid_nxt;
         data_o     <= data_nxt;
         underrun_o <= under_nxt;
         busy_o     <= busy_nxt;
         byte_ready <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_bpsk_framer.sv
// Scoreboard bench for bpsk_framer: frame model pushes (edge, bit) pairs, monitor pops on valid_o.
module tb_bpsk_framer;

   localparam int         D     = 4;
   localparam int         P     = 4;
   localparam logic [7:0] SFD_V = 8'hD5;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data  = 8'h00;
   logic       byte_last  = 1'b0;
   logic       byte_ready, valid_o, data_o, busy_o, underrun_o;

   typedef struct {
      int en;
      bit b;
   } exp_t;

   exp_t       sbq[$];
   int         uq[$];
   logic [7:0] fb[$];
   exp_t       mx;
   int         mu;
   int         edge_cnt = 0;
   int         tests = 0;
   int         fails = 0;

   bpsk_framer #(.SYM_DIV(D), .PREAMBLE_LEN(P), .SFD(SFD_V)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .busy_o     (busy_o),
      .underrun_o (underrun_o)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Monitor: every strobe / underrun pulse must match the head of its queue.
   always @(negedge CLK) begin
      if (RST) begin
         if (valid_o) begin
            if (sbq.size() == 0) begin
               tests++; fails++;
               $display("FAIL strobe_unexpected: strobe at edge %0d data %0d, none required", edge_cnt, data_o);
            end else begin
               mx = sbq.pop_front();
               chk("strobe_edge", edge_cnt, mx.en);
               chk("strobe_bit", int'(data_o), int'(mx.b));
            end
         end
         if (underrun_o) begin
            if (uq.size() == 0) begin
               tests++; fails++;
               $display("FAIL underrun_unexpected: pulse at edge %0d, none required", edge_cnt);
            end else begin
               mu = uq.pop_front();
               chk("underrun_edge", edge_cnt, mu);
            end
         end
      end
   end

   // Reference: the bit list of a frame, symbol k at edge e+1+k*D.
   task automatic push_frame(input int e, input int nbytes);
      bit   bits[$];
      exp_t x;
      for (int k = 0; k < P; k++) bits.push_back(k % 2 == 0);
      for (int i = 0; i < 8; i++) bits.push_back(SFD_V[i]);
      for (int b = 0; b < nbytes; b++)
         for (int i = 0; i < 8; i++) bits.push_back(fb[b][i]);
      foreach (bits[k]) begin
         x.en = e + 1 + k * D;
         x.b  = bits[k];
         sbq.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic wait_edge(input int n);
      int guard = 0;
      while (edge_cnt < n && guard < 5000) begin @(posedge CLK); #1; guard++; end
   endtask

   // Holds byte_valid until a transfer; acc is the transfer edge.
   task automatic send_byte(input logic [7:0] d, input bit last, output int acc);
      int budget = 0;
      byte_valid = 1'b1; byte_data = d; byte_last = last;
      while (!byte_ready && budget < 1000) begin @(posedge CLK); #1; budget++; end
      if (!byte_ready) begin
         tests++; fails++;
         $display("FAIL handshake_timeout: byte %0h never accepted, ready stayed 0", d);
         acc = -1;
      end else begin
         acc = edge_cnt + 1;
         @(posedge CLK); #1;
      end
      byte_valid = 1'b0; byte_last = 1'b0;
   endtask

   // Sends fb[0..stop-1] of an n-byte frame; stop<n withholds byte 'stop'.
   task automatic run_frame(input int n, input int stop, input bit stall, input bit late);
      int e, acc, t_end;
      send_byte(fb[0], n == 1, e);
      push_frame(e, stop);
      for (int b = 1; b < stop; b++) begin
         if (!(stall && b == 1)) idle($urandom_range(0, 3 * D));
         send_byte(fb[b], b == n - 1, acc);
         if (stall && b == 1) chk("stall_accept_edge", acc, e + 2 + (P + 8) * D);
      end
      t_end = e + 1 + (P + 8 + 8 * stop) * D;
      if (stop < n) uq.push_back(t_end);
      wait_edge(t_end - 1);
      chk("busy_before_end", int'(busy_o), 1);
      if (late && stop < n) begin
         chk("late_ready", int'(byte_ready), 1);
         byte_valid = 1'b1; byte_data = fb[stop]; byte_last = 1'b0;
         @(posedge CLK); #1;
         byte_valid = 1'b0;
      end
      wait_edge(t_end);
      chk("busy_after_end", int'(busy_o), 0);
      chk("ready_after_end", int'(byte_ready), 1);
   endtask

   initial begin
      int n, stop, e;
      bit late;

      #2 RST = 1'b0;
      #1;
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_data", int'(data_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_underrun", int'(underrun_o), 0);
      chk("rst_ready", int'(byte_ready), 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("ready_first_edge", int'(byte_ready), 1);

      // single byte
      fb.delete(); fb.push_back(8'h01);
      run_frame(1, 1, 1'b0, 1'b0);

      // three-byte frame, back-to-back with the previous one
      fb.delete(); fb.push_back(8'hA5); fb.push_back(8'h00); fb.push_back(8'hFF);
      run_frame(3, 3, 1'b0, 1'b0);

      // second byte withheld
      idle(3);
      fb.delete(); fb.push_back(8'h3C); fb.push_back(8'h99); fb.push_back(8'hC3);
      run_frame(3, 1, 1'b0, 1'b0);

      // byte_valid held from preamble onwards
      fb.delete(); fb.push_back(8'h5A); fb.push_back(8'h81);
      run_frame(2, 2, 1'b1, 1'b0);

      // transfer exactly on the deadline edge still underruns
      fb.delete(); fb.push_back(8'h12); fb.push_back(8'h34); fb.push_back(8'h56);
      run_frame(3, 2, 1'b0, 1'b1);

      // randomized frames
      for (int r = 0; r < 6; r++) begin
         idle($urandom_range(0, 5));
         n = $urandom_range(1, 4);
         fb.delete();
         for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
         stop = n;
         late = 1'b0;
         if (n > 1 && $urandom_range(0, 2) == 0) begin
            stop = $urandom_range(1, n - 1);
            late = 1'($urandom_range(0, 1));
         end
         run_frame(n, stop, 1'b0, late);
      end

      // reset in the middle of the first payload byte
      fb.delete(); fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
      send_byte(fb[0], 1'b0, e);
      push_frame(e, 1);
      wait_edge(e + 1 + (P + 8) * D + 2);
      chk("pre_rst_busy", int'(busy_o), 1);
      RST = 1'b0;
      #1;
      chk("midrst_valid", int'(valid_o), 0);
      chk("midrst_data", int'(data_o), 0);
      chk("midrst_busy", int'(busy_o), 0);
      chk("midrst_underrun", int'(underrun_o), 0);
      chk("midrst_ready", int'(byte_ready), 0);
      sbq.delete(); uq.delete();
      repeat (2) @(posedge CLK);
      #1 chk("ready_held_in_rst", int'(byte_ready), 0);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("ready_after_midrst", int'(byte_ready), 1);
      fb.delete(); fb.push_back(8'($urandom));
      run_frame(1, 1, 1'b0, 1'b0);

      idle(2 * D);
      chk("strobes_left", sbq.size(), 0);
      chk("underruns_left", uq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not complete, %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
